alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single `alu_main` datapath between two independent requesters, such as the instruction pipeline and a multiply/divide or address-generation helper. Each request carries operands and an opcode. The block grants one requester, drives the ALU from registered operands, and captures result plus Z/OV/N flags into a response register. The response is held until the owning requester accepts it. It sits between the requesters and the ALU instance and is the only block that drives the ALU inputs.

## Interface
Parameters:
- `DATA_W`, 16, operand/result width; fixed to 16 to match the ALU.
- `OP_W`, 3, opcode width; fixed to 3.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  one-cycle pulse on the cycle that requester's operation is accepted.
- `req0_p1`, `req0_p2` / `req1_p1`, `req1_p2`  in  16  operands.
- `req0_op` / `req1_op`  in  3  ALU opcode (000 add, 001 sub, 010 xor, 011 sll, 100 srl, 101 sra, 110 ll, 111 lh).
- `resp0_valid` / `resp1_valid`  out  1  response pending for that requester.
- `resp0_ready` / `resp1_ready`  in  1  requester accepts its response.
- `resp_result`  out  16  captured result; shared bus, qualified by `resp*_valid`.
- `resp_z`, `resp_ov`, `resp_n`  out  1  captured flags.
- `alu_p1`, `alu_p2`  out  16  ALU operands.
- `alu_opcode`  out  3  ALU opcode.
- `alu_result`  in  16  ALU result.
- `alu_z`, `alu_ov`, `alu_n`  in  1  ALU flags.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - If any `reqN_valid` is high, select a winner, pulse its `reqN_ready`, register its p1/p2/op and owner ID, then go to EXEC.
  - If no request is pending, stay in IDLE.
- **EXEC**
  - `alu_p1`, `alu_p2` and `alu_opcode` are driven from the operand register.
  - At the end of the cycle, capture `alu_result`, `alu_z` and `alu_n` into the response register.
  - Capture `alu_ov` only when the opcode is 000 or 001. For all other opcodes the captured `resp_ov` is forced to 0, because ALU OV is not defined for them.
  - Go to RESP.
- **RESP**
  - Assert the owner's `respN_valid`; the other `respN_valid` stays 0.
  - Hold the result and flags stable until the owner's `respN_ready` is high. On that edge, clear `respN_valid` and go to IDLE.
  - New requests are not accepted in EXEC or RESP; `reqN_ready` stays 0 in those states.
- **Arbitration**
  - A lone request always wins.
  - Simultaneous requests are resolved by the arbitration policy (see Configuration).
  - A requester must hold its valid and operands stable until ready; the block samples them only on the ready cycle.
- **Outputs between operations**
  - `alu_*` outputs hold the last registered values in all states.
  - `resp_*` data holds the last captured values after the handshake.
- **Reset mid-operation**
  - Any state returns to IDLE. Pending responses are dropped.
  - Operand, response and grant-pointer registers are cleared.

## Timing
- Reset values: `req0_ready`, `req1_ready`, `resp0_valid` and `resp1_valid` are 0; `resp_result` = 0x0000; `resp_z`, `resp_ov` and `resp_n` are 0; `alu_p1`, `alu_p2` = 0x0000; `alu_opcode` = 000.
- The grant pointer resets so that requester 0 wins the first contention.
- Let the accept (ready) cycle be T:
  - Operands appear on `alu_*` in cycle T+1.
  - Result is captured at the end of T+1.
  - `respN_valid` is high from cycle T+2.
- Minimum turnaround is 3 cycles per operation when `respN_ready` is high in T+2. Each extra cycle of response backpressure adds one cycle.
- The ALU is combinational. Its path from `alu_*` to the capture register must close in one cycle.

## Configuration
- Macro `ALU_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - On simultaneous requests, grant the requester not granted last.
  - The pointer updates on every grant, including uncontested ones.
- **Undefined:** fixed priority. Requester 0 always wins contention and the pointer logic is removed. Requester 1 can starve.

## Test plan
- Reset, then idle for 5 cycles: all valid and ready outputs are 0, `resp_result` = 0x0000, `alu_opcode` = 000.
- Req0 add, p1 = 0x7FFF, p2 = 0x0001, resp0_ready held high:
  - `req0_ready` pulses at T.
  - `resp0_valid` is high at T+2 with result 0x8000, ov = 1, n = 1, z = 0.
- Req1 xor, p1 = 0x00FF, p2 = 0x00FF:
  - result 0x0000, z = 1, ov = 0 (forced), n = 0.
  - `resp1_valid` is high and `resp0_valid` stays 0.
- Both requesters valid continuously, 4 operations, with `ALU_ARB_RR_EN` defined: grants go 0, 1, 0, 1.
  - Without the macro: all four grants go to 0 while req0 stays valid.
- Req0 sub 0x0005 − 0x0007, resp0_ready held low for 4 cycles:
  - `resp0_valid` stays high and result 0xFFFE with n = 1 is stable.
  - No new grant occurs while resp0_ready is low.
  - Accept happens on the 5th cycle, and the next grant comes no earlier than the following cycle.
- Assert `rst` for one cycle during EXEC of a req1 operation:
  - No `resp1_valid` is ever raised for it.
  - The FSM is in IDLE and, with both requesting afterwards, req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared alu_main datapath: grant, register operands, capture result/flags, hold for the owner.
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration; without it requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_p1,
  input  logic [DATA_W-1:0] req0_p2,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_p1,
  input  logic [DATA_W-1:0] req1_p2,
  input  logic [OP_W-1:0]   req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_z,
  output logic              resp_ov,
  output logic              resp_n,
  output logic [DATA_W-1:0] alu_p1,
  output logic [DATA_W-1:0] alu_p2,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_ov,
  input  logic              alu_n,
  output logic [1:0]        dbg_state
);

  // Handshakes: reqN_ready is a one-cycle pulse in IDLE; the request transfers on the
  // edge where valid and ready are both high. respN_valid stays high in RESP until the
  // edge where respN_ready is high, which completes the transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;

  state_t state, state_nxt;
  logic   owner;
  logic   grant_sel;
  logic   accept;
  logic   ov_defined;

  assign dbg_state = state;
  assign accept    = (state == IDLE) && !rst && (req0_valid || req1_valid);

`ifdef ALU_ARB_RR_EN
  // rr_ptr names the requester that wins the next contention.
  logic rr_ptr;

  assign grant_sel = (req0_valid && req1_valid) ? rr_ptr : req1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant_sel;
    end
  end
`else
  assign grant_sel = ~req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = accept && !grant_sel;
        req1_ready = accept && grant_sel;
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        resp0_valid = !owner;
        resp1_valid = owner;
        if (owner ? resp1_ready : resp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The operand register drives the ALU directly and holds between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_p1     <= '0;
      alu_p2     <= '0;
      alu_opcode <= '0;
      owner      <= 1'b0;
    end else if (accept) begin
      alu_p1     <= grant_sel ? req1_p1 : req0_p1;
      alu_p2     <= grant_sel ? req1_p2 : req0_p2;
      alu_opcode <= grant_sel ? req1_op : req0_op;
      owner      <= grant_sel;
    end
  end

  // ALU overflow is only meaningful for add and sub.
  assign ov_defined = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_result <= '0;
      resp_z      <= 1'b0;
      resp_ov     <= 1'b0;
      resp_n      <= 1'b0;
    end else if (state == EXEC) begin
      resp_result <= alu_result;
      resp_z      <= alu_z;
      resp_ov     <= ov_defined && alu_ov;
      resp_n      <= alu_n;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: stand-in ALU, transaction-level reference model, per-cycle compare.
// Build with or without ALU_ARB_RR_EN; expectations follow the same macro.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_p1, req0_p2, req1_p1, req1_p2;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [15:0] resp_result;
  logic        resp_z, resp_ov, resp_n;
  logic [15:0] alu_p1, alu_p2;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        alu_z, alu_ov, alu_n;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_p1(req0_p1), .req0_p2(req0_p2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_p1(req1_p1), .req1_p2(req1_p2), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_z(resp_z), .resp_ov(resp_ov), .resp_n(resp_n),
    .alu_p1(alu_p1), .alu_p2(alu_p2), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_z(alu_z), .alu_ov(alu_ov), .alu_n(alu_n),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        ov;
    logic        n;
  } alu_out_t;

  // Stand-in ALU; drives OV high for opcodes where it has no meaning so masking is visible.
  function automatic alu_out_t alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_out_t o;
    o.ov = 1'b1;
    case (op)
      3'd0: begin o.r = a + b; o.ov = (a[15] == b[15]) && (o.r[15] != a[15]); end
      3'd1: begin o.r = a - b; o.ov = (a[15] != b[15]) && (o.r[15] != a[15]); end
      3'd2: o.r = a ^ b;
      3'd3: o.r = a << b[3:0];
      3'd4: o.r = a >> b[3:0];
      3'd5: o.r = $signed(a) >>> b[3:0];
      3'd6: o.r = {a[15:8], b[7:0]};
      default: o.r = {b[7:0], a[7:0]};
    endcase
    o.z = (o.r == 16'h0000);
    o.n = o.r[15];
    return o;
  endfunction

  function automatic alu_out_t ref_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_out_t o;
    o = alu_fn(op, a, b);
    if (op > 3'd1) o.ov = 1'b0;
    return o;
  endfunction

  alu_out_t alu_o;
  always_comb alu_o = alu_fn(alu_opcode, alu_p1, alu_p2);
  assign alu_result = alu_o.r;
  assign alu_z      = alu_o.z;
  assign alu_ov     = alu_o.ov;
  assign alu_n      = alu_o.n;

  // ---------------- reference model (transaction level) ----------------
  int          cyc = 0;
  int          g_cyc = 0;
  bit          busy = 1'b0;
  bit          owner = 1'b0;
  logic [15:0] m_p1 = '0, m_p2 = '0;
  logic [2:0]  m_op = '0;
  alu_out_t    prev_r = '0, cur_r = '0;
  bit          chk_en = 1'b0;
`ifdef ALU_ARB_RR_EN
  bit          rr_pref = 1'b0;
`endif

  function automatic bit pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return rr_pref;
`else
      return 1'b0;
`endif
    end
    return v1 && !v0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0; m_p1 = '0; m_p2 = '0; m_op = '0; prev_r = '0; cur_r = '0;
`ifdef ALU_ARB_RR_EN
      rr_pref = 1'b0;
`endif
    end else if (busy) begin
      if (cyc >= g_cyc + 2 && (owner ? resp1_ready : resp0_ready)) busy = 1'b0;
    end else if (req0_valid || req1_valid) begin
      owner  = pick(req0_valid, req1_valid);
      busy   = 1'b1;
      g_cyc  = cyc;
      m_p1   = owner ? req1_p1 : req0_p1;
      m_p2   = owner ? req1_p2 : req0_p2;
      m_op   = owner ? req1_op : req0_op;
      prev_r = cur_r;
      cur_r  = ref_fn(m_op, m_p1, m_p2);
`ifdef ALU_ARB_RR_EN
      rr_pref = ~owner;
`endif
    end
    cyc++;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit       e_acc, e_w, e_rv;
  alu_out_t e_rd;
  always @(negedge clk) begin
    if (chk_en) begin
      e_w   = pick(req0_valid, req1_valid);
      e_acc = !rst && !busy && (req0_valid || req1_valid);
      e_rv  = busy && (cyc >= g_cyc + 2);
      e_rd  = (busy && cyc < g_cyc + 2) ? prev_r : cur_r;
      chk1("req0_ready", req0_ready, e_acc && !e_w);
      chk1("req1_ready", req1_ready, e_acc && e_w);
      chk1("resp0_valid", resp0_valid, e_rv && !owner);
      chk1("resp1_valid", resp1_valid, e_rv && owner);
      chk16("alu_p1", alu_p1, m_p1);
      chk16("alu_p2", alu_p2, m_p2);
      chk16("alu_opcode", {13'b0, alu_opcode}, {13'b0, m_op});
      chk16("resp_result", resp_result, e_rd.r);
      chk1("resp_z", resp_z, e_rd.z);
      chk1("resp_ov", resp_ov, e_rd.ov);
      chk1("resp_n", resp_n, e_rd.n);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = n ? req1_ready : req0_ready;
    end
    chk1(n ? "grant1_timeout" : "grant0_timeout", seen, 1'b1);
  endtask

  bit       acc0, acc1;
  bit [1:0] gq[$];
  bit       last_g;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_p1 = '0; req0_p2 = '0; req0_op = '0;
    req1_p1 = '0; req1_p2 = '0; req1_op = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (5) begin
      @(negedge clk);
      chk1("idle_req0_ready", req0_ready, 1'b0);
      chk1("idle_req1_ready", req1_ready, 1'b0);
      chk1("idle_resp0_valid", resp0_valid, 1'b0);
      chk1("idle_resp1_valid", resp1_valid, 1'b0);
      chk16("idle_result", resp_result, 16'h0000);
      chk16("idle_opcode", {13'b0, alu_opcode}, 16'h0000);
    end

    // Add with signed overflow
    step();
    resp0_ready = 1'b1;
    req0_valid = 1'b1; req0_p1 = 16'h7FFF; req0_p2 = 16'h0001; req0_op = 3'd0;
    wait_ready(1'b0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk1("add_t1_resp0_valid", resp0_valid, 1'b0);
    @(negedge clk);
    chk1("add_resp0_valid", resp0_valid, 1'b1);
    chk16("add_result", resp_result, 16'h8000);
    chk1("add_ov", resp_ov, 1'b1);
    chk1("add_n", resp_n, 1'b1);
    chk1("add_z", resp_z, 1'b0);

    // Xor on requester 1: zero result, OV forced low
    step();
    resp1_ready = 1'b1;
    req1_valid = 1'b1; req1_p1 = 16'h00FF; req1_p2 = 16'h00FF; req1_op = 3'd2;
    wait_ready(1'b1);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("xor_resp1_valid", resp1_valid, 1'b1);
    chk1("xor_resp0_valid", resp0_valid, 1'b0);
    chk16("xor_result", resp_result, 16'h0000);
    chk1("xor_z", resp_z, 1'b1);
    chk1("xor_ov", resp_ov, 1'b0);
    chk1("xor_n", resp_n, 1'b0);

    // Contention: both requesters valid continuously
    step();
    req0_valid = 1'b1; req0_p1 = 16'h1234; req0_p2 = 16'h0101; req0_op = 3'd0;
    req1_valid = 1'b1; req1_p1 = 16'h8000; req1_p2 = 16'h0003; req1_op = 3'd5;
    gq.delete();
    for (int c = 0; c < 40 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (req0_ready) gq.push_back(2'd0);
      else if (req1_ready) gq.push_back(2'd1);
    end
    chk16("contention_grant_count", 16'(gq.size()), 16'd4);
    for (int i = 0; i < gq.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      chk16($sformatf("rr_grant_%0d", i), {14'b0, gq[i]}, (i % 2 == 0) ? 16'd0 : 16'd1);
`else
      chk16($sformatf("fixed_grant_%0d", i), {14'b0, gq[i]}, 16'd0);
`endif
    end
    last_g = (gq.size() > 0) ? gq[gq.size()-1][0] : 1'b0;
    step();
    if (last_g) req1_valid = 1'b0; else req0_valid = 1'b0;
    wait_ready(!last_g);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();

    // Response backpressure
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_p1 = 16'h0005; req0_p2 = 16'h0007; req0_op = 3'd1;
    wait_ready(1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_p1 = 16'h0F0F; req1_p2 = 16'h00F0; req1_op = 3'd2;
    @(negedge clk);
    chk1("bp_t1_req1_ready", req1_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("bp_resp0_valid", resp0_valid, 1'b1);
      chk16("bp_result", resp_result, 16'hFFFE);
      chk1("bp_n", resp_n, 1'b1);
      chk1("bp_req1_ready", req1_ready, 1'b0);
    end
    step();
    resp0_ready = 1'b1;
    @(negedge clk);
    chk1("bp_accept_resp0_valid", resp0_valid, 1'b1);
    chk1("bp_accept_req1_ready", req1_ready, 1'b0);
    step();
    resp0_ready = 1'b0;
    @(negedge clk);
    chk1("bp_after_resp0_valid", resp0_valid, 1'b0);
    chk1("bp_after_req1_ready", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    repeat (4) step();

    // Randomized traffic with occasional resets
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_p1 = 16'($urandom); req0_p2 = 16'($urandom); req0_op = 3'($urandom_range(0, 7));
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_p1 = 16'($urandom); req1_p2 = 16'($urandom); req1_op = 3'($urandom_range(0, 7));
      end
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      acc0 = req0_ready; acc1 = req1_ready;
    end
    for (int c = 0; c < 30; c++) begin
      step();
      rst = 1'b0;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      @(negedge clk);
      acc0 = req0_ready; acc1 = req1_ready;
    end
    chk1("drain_req0", req0_valid, 1'b0);
    chk1("drain_req1", req1_valid, 1'b0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();

    // Reset during EXEC of a requester-1 operation
    resp1_ready = 1'b1;
    req1_valid = 1'b1; req1_p1 = 16'h4000; req1_p2 = 16'h4000; req1_op = 3'd0;
    wait_ready(1'b1);
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk16("rst_state_idle", {14'b0, dbg_state}, 16'd0);
    chk16("rst_result_cleared", resp_result, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1("rst_no_resp1", resp1_valid, 1'b0);
    end
    step();
    req0_valid = 1'b1; req0_p1 = 16'h0003; req0_p2 = 16'h0002; req0_op = 3'd3;
    req1_valid = 1'b1; req1_p1 = 16'h0003; req1_p2 = 16'h0002; req1_op = 3'd4;
    resp0_ready = 1'b1;
    @(negedge clk);
    chk1("post_rst_req0_first", req0_ready, 1'b1);
    chk1("post_rst_req1_wait", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    wait_ready(1'b1);
    step();
    req1_valid = 1'b0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
